// File: rtl/rtc_bus_sequencer.sv
// RTC parallel-bus transaction controller: arbitrates init vs user requests and
// sequences the address/data phases, selector controls and CS#/AD/WR#/RD# strobes.
module rtc_bus_sequencer #(
  parameter int T_SU = 2,
  parameter int T_PW = 4,
  parameter int T_H  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ini_valid,
  input  logic       ini_write,
  input  logic [7:0] ini_addr,
  input  logic [7:0] ini_wdata,
  output logic       ini_ready,
  input  logic       usr_valid,
  input  logic       usr_write,
  input  logic [7:0] usr_addr,
  input  logic [7:0] usr_wdata,
  output logic       usr_ready,
  input  logic [7:0] rd_in,
  output logic       done,
  output logic       done_ini,
  output logic [7:0] rdata,
  output logic       sel_write,
  output logic       sel_data,
  output logic       sel_drive,
  output logic       sel_init,
  output logic [7:0] addr_out,
  output logic [7:0] wdata_out,
  output logic [7:0] ini_data_out,
  output logic       rtc_cs_n,
  output logic       rtc_ad,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam logic [7:0] L_SU = 8'(T_SU - 1);
  localparam logic [7:0] L_PW = 8'(T_PW - 1);
  localparam logic [7:0] L_H  = 8'(T_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_A_SU, S_A_PW, S_A_H, S_D_SU, S_D_PW, S_D_H, S_DONE
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_load;
  logic       r_write, w_write_nx, w_cnt_zero;
  logic       w_ini_acc, w_usr_acc;
  logic       w_a, w_d, w_apw, w_dpw;

  // Handshake: a request is accepted in the cycle its valid and ready are both
  // high; ready is only ever raised in IDLE, init has fixed priority over user.
  assign w_ini_acc  = (r_state == S_IDLE) && ini_valid;
  assign w_usr_acc  = (r_state == S_IDLE) && !ini_valid && usr_valid;
  assign ini_ready  = w_ini_acc;
  assign usr_ready  = w_usr_acc;
  assign w_cnt_zero = (r_cnt == 8'd0);
  assign dbg_state  = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_ini_acc || w_usr_acc) w_next = S_A_SU;
      S_A_SU: if (w_cnt_zero) w_next = S_A_PW;
      S_A_PW: if (w_cnt_zero) w_next = S_A_H;
      S_A_H:  if (w_cnt_zero) w_next = S_D_SU;
      S_D_SU: if (w_cnt_zero) w_next = S_D_PW;
      S_D_PW: if (w_cnt_zero) w_next = S_D_H;
      S_D_H:  if (w_cnt_zero) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 8'd0;
    case (w_next)
      S_A_SU, S_D_SU: w_load = L_SU;
      S_A_PW, S_D_PW: w_load = L_PW;
      S_A_H,  S_D_H:  w_load = L_H;
      default:        w_load = 8'd0;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  assign w_write_nx = w_ini_acc ? ini_write : (w_usr_acc ? usr_write : r_write);
  assign w_a   = (w_next == S_A_SU) || (w_next == S_A_PW) || (w_next == S_A_H);
  assign w_d   = (w_next == S_D_SU) || (w_next == S_D_PW) || (w_next == S_D_H);
  assign w_apw = (w_next == S_A_PW);
  assign w_dpw = (w_next == S_D_PW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_write      <= 1'b0;
      addr_out     <= 8'd0;
      wdata_out    <= 8'd0;
      ini_data_out <= 8'd0;
      sel_init     <= 1'b0;
      rdata        <= 8'd0;
      busy         <= 1'b0;
      rtc_cs_n     <= 1'b1;
      rtc_ad       <= 1'b0;
      rtc_wr_n     <= 1'b1;
      rtc_rd_n     <= 1'b1;
      sel_write    <= 1'b0;
      sel_data     <= 1'b0;
      sel_drive    <= 1'b0;
      done         <= 1'b0;
      done_ini     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= w_load;
      else if (!w_cnt_zero)
        r_cnt <= r_cnt - 8'd1;
      r_write <= w_write_nx;
      if (w_ini_acc) begin
        addr_out     <= ini_addr;
        ini_data_out <= ini_wdata;
        sel_init     <= 1'b1;
      end else if (w_usr_acc) begin
        addr_out  <= usr_addr;
        wdata_out <= usr_wdata;
        sel_init  <= 1'b0;
      end
      // Capture on the edge that closes the final read-strobe cycle.
      if ((r_state == S_D_PW) && w_cnt_zero && !r_write)
        rdata <= rd_in;
      busy      <= (w_next != S_IDLE);
      rtc_cs_n  <= !(w_a || w_d);
      rtc_ad    <= w_a;
      rtc_wr_n  <= !(w_apw || (w_dpw && w_write_nx));
      rtc_rd_n  <= !(w_dpw && !w_write_nx);
      sel_write <= w_a || (w_d && w_write_nx);
      sel_data  <= w_d;
      sel_drive <= w_a || (w_d && w_write_nx);
      done      <= (w_next == S_DONE);
      done_ini  <= (w_next == S_DONE) && sel_init;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: directed transactions, a done-pulse scoreboard,
// per-cycle strobe tables and a fast-timing instance.
module tb_rtc_bus_sequencer;
  localparam int W = 25;  // {done_ini, rdata, done cycle[15:0]}

  logic clk = 1'b0, reset = 1'b1;
  logic ini_valid = 0, ini_write = 0, usr_valid = 0, usr_write = 0;
  logic [7:0] ini_addr = 0, ini_wdata = 0, usr_addr = 0, usr_wdata = 0, rd_in = 0;
  logic ini_ready, usr_ready, done, done_ini, sel_write, sel_data, sel_drive, sel_init;
  logic [7:0] rdata, addr_out, wdata_out, ini_data_out;
  logic rtc_cs_n, rtc_ad, rtc_wr_n, rtc_rd_n, busy;
  logic [2:0] dbg_state;

  logic f_usr_valid = 0, f_usr_write = 0;
  logic [7:0] f_usr_addr = 0, f_usr_wdata = 0;
  logic f_ini_ready, f_usr_ready, f_done, f_done_ini, f_sel_write, f_sel_data, f_sel_drive, f_sel_init;
  logic [7:0] f_rdata, f_addr_out, f_wdata_out, f_ini_data_out;
  logic f_cs_n, f_ad, f_wr_n, f_rd_n, f_busy;
  logic [2:0] f_dbg_state;

  int cyc = 0;
  int n_checks = 0, n_errors = 0;
  logic [7:0] rd_model = 8'h00;
  logic [W-1:0] exp_q[$];

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset),
    .ini_valid(ini_valid), .ini_write(ini_write), .ini_addr(ini_addr), .ini_wdata(ini_wdata), .ini_ready(ini_ready),
    .usr_valid(usr_valid), .usr_write(usr_write), .usr_addr(usr_addr), .usr_wdata(usr_wdata), .usr_ready(usr_ready),
    .rd_in(rd_in), .done(done), .done_ini(done_ini), .rdata(rdata),
    .sel_write(sel_write), .sel_data(sel_data), .sel_drive(sel_drive), .sel_init(sel_init),
    .addr_out(addr_out), .wdata_out(wdata_out), .ini_data_out(ini_data_out),
    .rtc_cs_n(rtc_cs_n), .rtc_ad(rtc_ad), .rtc_wr_n(rtc_wr_n), .rtc_rd_n(rtc_rd_n),
    .busy(busy), .dbg_state(dbg_state)
  );

  rtc_bus_sequencer #(.T_SU(1), .T_PW(1), .T_H(1)) u_fast (
    .clk(clk), .reset(reset),
    .ini_valid(1'b0), .ini_write(1'b0), .ini_addr(8'h00), .ini_wdata(8'h00), .ini_ready(f_ini_ready),
    .usr_valid(f_usr_valid), .usr_write(f_usr_write), .usr_addr(f_usr_addr), .usr_wdata(f_usr_wdata),
    .usr_ready(f_usr_ready), .rd_in(8'h00), .done(f_done), .done_ini(f_done_ini), .rdata(f_rdata),
    .sel_write(f_sel_write), .sel_data(f_sel_data), .sel_drive(f_sel_drive), .sel_init(f_sel_init),
    .addr_out(f_addr_out), .wdata_out(f_wdata_out), .ini_data_out(f_ini_data_out),
    .rtc_cs_n(f_cs_n), .rtc_ad(f_ad), .rtc_wr_n(f_wr_n), .rtc_rd_n(f_rd_n),
    .busy(f_busy), .dbg_state(f_dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc < t && n < 1000);
    if (cyc != t) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_cyc: got cycle %0d expected %0d", cyc, t);
    end
  endtask

  // Hand-derived strobe table for default timing: A phase cycles 1-8, D phase 9-16,
  // strobe-low windows 3-6 and 11-14, DONE at 17.
  function automatic logic [7:0] exp_sig(input int k, input bit wr);
    bit a, d, apw, dpw;
    a = (k >= 1 && k <= 8);
    d = (k >= 9 && k <= 16);
    apw = (k >= 3 && k <= 6);
    dpw = (k >= 11 && k <= 14);
    return {!(a || d), a, !(apw || (dpw && wr)), !(dpw && !wr),
            a || (d && wr), d, a || (d && wr), (k >= 1 && k <= 17)};
  endfunction

  task automatic check_wave(input int acc, input bit wr);
    for (int k = 1; k <= 17; k++) begin
      wait_cyc(acc + k);
      check($sformatf("wave_%s_c%0d", wr ? "wr" : "rd", k),
            {rtc_cs_n, rtc_ad, rtc_wr_n, rtc_rd_n, sel_write, sel_data, sel_drive, busy},
            exp_sig(k, wr));
    end
  endtask

  // Driver tasks
  task automatic issue_usr(input logic w, input logic [7:0] a, input logic [7:0] d, output int acc);
    int n;
    acc = -1;
    @(negedge clk);
    usr_valid = 1; usr_write = w; usr_addr = a; usr_wdata = d;
    for (n = 0; n < 100; n++) begin
      #1;
      if (usr_ready) break;
      @(negedge clk);
    end
    if (n == 100) begin
      check("usr_accept_timeout", 32'd0, 32'd1);
      usr_valid = 0;
      return;
    end
    acc = cyc;
    if (!w) rd_model = rd_in;
    exp_q.push_back({1'b0, rd_model, 16'(acc + 17)});
    @(posedge clk);
    #1 usr_valid = 0;
    check("usr_addr_out", addr_out, a);
    check("usr_sel_init", sel_init, 1'b0);
    if (w) check("usr_wdata_out", wdata_out, d);
  endtask

  task automatic issue_ini(input logic w, input logic [7:0] a, input logic [7:0] d, output int acc);
    int n;
    acc = -1;
    @(negedge clk);
    ini_valid = 1; ini_write = w; ini_addr = a; ini_wdata = d;
    for (n = 0; n < 100; n++) begin
      #1;
      if (ini_ready) break;
      @(negedge clk);
    end
    if (n == 100) begin
      check("ini_accept_timeout", 32'd0, 32'd1);
      ini_valid = 0;
      return;
    end
    acc = cyc;
    check("loser_usr_ready", usr_ready, 1'b0);
    if (!w) rd_model = rd_in;
    exp_q.push_back({1'b1, rd_model, 16'(acc + 17)});
    @(posedge clk);
    #1 ini_valid = 0;
    check("ini_addr_out", addr_out, a);
    check("ini_sel_init", sel_init, 1'b1);
    if (w) check("ini_data_out", ini_data_out, d);
  endtask

  // Scoreboard monitor: pops one expected response per done pulse.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("done_ini", done_ini, e[24]);
        check("done_rdata", rdata, e[23:16]);
        check("done_cycle", cyc[15:0], e[15:0]);
      end
    end
  end

  initial begin
    int acc, acc_i, acc_u;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", {rtc_cs_n, rtc_ad, rtc_wr_n, rtc_rd_n, sel_write, sel_data, sel_drive, busy}, 8'b1011_0000);
    check("reset_flags", {done, done_ini, ini_ready, usr_ready, sel_init}, 5'b0);
    check("reset_data", {rdata, addr_out, wdata_out, ini_data_out}, 32'h0);
    reset = 0;

    issue_usr(1'b1, 8'h21, 8'h45, acc);
    check_wave(acc, 1'b1);
    wait_cyc(acc + 18);

    rd_in = 8'h59;
    issue_usr(1'b0, 8'h23, 8'h00, acc);
    check_wave(acc, 1'b0);
    wait_cyc(acc + 18);
    check("rdata_hold", rdata, 8'h59);

    fork
      issue_ini(1'b1, 8'h0A, 8'h3C, acc_i);
      issue_usr(1'b1, 8'h0B, 8'h77, acc_u);
    join
    check("arb_user_delay", acc_u - acc_i, 32'd18);
    wait_cyc(acc_u + 18);

    issue_usr(1'b1, 8'h30, 8'h99, acc);
    wait_cyc(acc + 12);
    #2 reset = 1;
    #1;
    check("midrst_strobes", {rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_ad}, 4'b1110);
    check("midrst_sel", {sel_write, sel_data, sel_drive, busy, done}, 5'b0);
    exp_q.delete();
    rd_model = 8'h00;
    check("midrst_rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (25) @(negedge clk);
    rd_in = 8'hA6;
    issue_usr(1'b0, 8'h31, 8'h00, acc);
    wait_cyc(acc + 18);

    @(negedge clk);
    f_usr_valid = 1; f_usr_write = 1; f_usr_addr = 8'h55; f_usr_wdata = 8'h12;
    #1 check("fast_ready", f_usr_ready, 1'b1);
    acc = cyc;
    @(posedge clk);
    #1 f_usr_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      wait_cyc(acc + k);
      check($sformatf("fast_wr_n_c%0d", k), f_wr_n, (k == 2 || k == 5) ? 1'b0 : 1'b1);
      check($sformatf("fast_done_c%0d", k), f_done, (k == 7) ? 1'b1 : 1'b0);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
